// File: rtl/jt51_pkg.sv
// Shared JT51 constants and the register 0x0F field layout used by the noise path.
package jt51_pkg;

  localparam int         JT51_SLOTS     = 32;
  localparam int         JT51_CNT_W     = $clog2(JT51_SLOTS);
  localparam logic [7:0] JT51_NOISE_REG = 8'h0F;
  localparam int         JT51_NE_BIT    = 7;
  localparam int         JT51_NFRQ_W    = 5;

  typedef struct packed {
    logic                   ne;
    logic [JT51_NFRQ_W-1:0] nfrq;
  } noise_cfg_t;

  // Slot that follows s in the operator cycle, wrapping at the frame end.
  function automatic int slot_after(input int s);
    return (s + 1) % JT51_SLOTS;
  endfunction

endpackage

// File: rtl/jt51_slot_cnt.sv
// 32-slot operator counter with resync on the timing generator's zero pulse,
// a sticky sync error flag and the half / noise-slot decodes.
module jt51_slot_cnt
  import jt51_pkg::*;
#(
  parameter int NOISE_SLOT = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic                  zero,
  output logic [JT51_CNT_W-1:0] cnt,
  output logic                  half,
  output logic                  op31_no,
  output logic                  sync_err
);

  localparam logic [JT51_CNT_W-1:0] NOISE_CNT = JT51_CNT_W'(NOISE_SLOT);

  // zero marks slot 0, so the slot after it is always 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sync_err <= 1'b0;
    end else if (cen) begin
      if (zero && cnt != '0) sync_err <= 1'b1;
      cnt <= zero ? JT51_CNT_W'(1) : cnt + JT51_CNT_W'(1);
    end
  end

  assign half    = (cnt[3:0] == 4'hF);
  assign op31_no = (cnt == NOISE_CNT);

endmodule

// File: rtl/jt51_noise_sched.sv
// Noise slot sequencer: frame-aligned application of register 0x0F, slot-31
// envelope capture and substitution of the noise mix on the operator path.
module jt51_noise_sched
  import jt51_pkg::*;
#(
  parameter int NOISE_SLOT = 31,
  parameter int MIXW       = 12,
  parameter int OPW        = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic                   zero,
  input  logic                   cfg_we,
  input  logic [7:0]             cfg_din,
  input  logic [9:0]             eg_in,
  input  logic signed [OPW-1:0]  op_in,
  input  logic signed [MIXW-1:0] noise_mix,
  output logic                   half,
  output logic                   op31_no,
  output logic [4:0]             nfrq,
  output logic                   ne,
  output logic [9:0]             eg_noise,
  output logic signed [OPW-1:0]  op_out,
  output logic                   cfg_pend,
  output logic                   sync_err
);

  localparam logic [JT51_CNT_W-1:0] MIX_CNT = JT51_CNT_W'(slot_after(NOISE_SLOT));

  logic [JT51_CNT_W-1:0] cnt;
  noise_cfg_t            wr_cfg;
  noise_cfg_t            shadow;
  noise_cfg_t            applied;
  logic signed [OPW-1:0] op_p1;
  logic [1:0]            unused_cfg_bits;

  function automatic logic signed [OPW-1:0] sext_mix(input logic signed [MIXW-1:0] v);
    return {{(OPW-MIXW){v[MIXW-1]}}, v};
  endfunction

  jt51_slot_cnt #(
    .NOISE_SLOT (NOISE_SLOT)
  ) u_slot_cnt (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .zero     (zero),
    .cnt      (cnt),
    .half     (half),
    .op31_no  (op31_no),
    .sync_err (sync_err)
  );

  assign wr_cfg.ne       = cfg_din[JT51_NE_BIT];
  assign wr_cfg.nfrq     = cfg_din[JT51_NFRQ_W-1:0];
  assign unused_cfg_bits = cfg_din[6:5];

  // The shadow is only consulted while cfg_pend is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cen && cfg_we) shadow <= wr_cfg;
  end

  // A write landing on the apply slot bypasses the shadow entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      applied  <= '0;
      cfg_pend <= 1'b0;
      eg_noise <= '0;
    end else if (cen) begin
      if (op31_no) begin
        if (cfg_we)        applied <= wr_cfg;
        else if (cfg_pend) applied <= shadow;
        cfg_pend <= 1'b0;
        eg_noise <= eg_in;
      end else if (cfg_we) begin
        cfg_pend <= 1'b1;
      end
    end
  end

  assign ne   = applied.ne;
  assign nfrq = applied.nfrq;

  // Stage p1: operator output, noise substituted on the slot after the noise slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_p1 <= '0;
    end else if (cen) begin
      op_p1 <= (cnt == MIX_CNT && applied.ne) ? sext_mix(noise_mix) : op_in;
    end
  end

  assign op_out = op_p1;

endmodule

// File: tb/tb_jt51_noise_sched.sv
// Self-checking bench for jt51_noise_sched against a slot-level reference model.
module tb_jt51_noise_sched;

  localparam int NS = 31;

  logic              clk = 1'b0;
  logic              rst;
  logic              cen;
  logic              zero;
  logic              cfg_we;
  logic [7:0]        cfg_din;
  logic [9:0]        eg_in;
  logic signed [13:0] op_in;
  logic signed [11:0] noise_mix;
  logic              half;
  logic              op31_no;
  logic [4:0]        nfrq;
  logic              ne;
  logic [9:0]        eg_noise;
  logic signed [13:0] op_out;
  logic              cfg_pend;
  logic              sync_err;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_cnt;
  bit       m_ne;
  int       m_nfrq;
  bit       m_pend;
  bit [7:0] m_shadow;
  int       m_eg;
  int       m_op;
  bit       m_err;
  int       prev_cnt;

  always #5 clk = ~clk;

  jt51_noise_sched #(.NOISE_SLOT(NS), .MIXW(12), .OPW(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .zero      (zero),
    .cfg_we    (cfg_we),
    .cfg_din   (cfg_din),
    .eg_in     (eg_in),
    .op_in     (op_in),
    .noise_mix (noise_mix),
    .half      (half),
    .op31_no   (op31_no),
    .nfrq      (nfrq),
    .ne        (ne),
    .eg_noise  (eg_noise),
    .op_out    (op_out),
    .cfg_pend  (cfg_pend),
    .sync_err  (sync_err)
  );

  task automatic model_clear();
    m_cnt = 0; m_ne = 0; m_nfrq = 0; m_pend = 0; m_shadow = 0;
    m_eg = 0; m_op = 0; m_err = 0; prev_cnt = 0;
  endtask

  // One clock; the model advances from the slot rules only when c is high.
  task automatic step(input bit c, input bit z, input bit we, input logic [7:0] din,
                      input logic [9:0] eg, input logic [13:0] op, input logic [11:0] mix);
    cen = c; zero = z; cfg_we = we; cfg_din = din; eg_in = eg; op_in = op; noise_mix = mix;
    @(posedge clk); #1;
    prev_cnt = m_cnt;
    if (c) begin
      if (z && m_cnt != 0) m_err = 1;
      if (m_cnt == (NS + 1) % 32 && m_ne)
        m_op = (int'(mix) >= 2048) ? int'(mix) - 4096 + 16384 : int'(mix);
      else
        m_op = int'(op);
      if (m_cnt == NS) begin
        if (we) begin m_ne = din[7]; m_nfrq = int'(din[4:0]); end
        else if (m_pend) begin m_ne = m_shadow[7]; m_nfrq = int'(m_shadow[4:0]); end
        m_pend = 0;
        m_eg = int'(eg);
      end else if (we) begin
        m_shadow = din;
        m_pend = 1;
      end
      m_cnt = z ? 1 : (m_cnt + 1) % 32;
    end
    cen = 0; cfg_we = 0; zero = 0;
  endtask

  task automatic adv_to(input int target);
    for (int k = 0; k < 64 && m_cnt != target; k++)
      step(1, m_cnt == 0, 0, 8'h00, 10'h000, 14'h0123, 12'h800);
  endtask

  task automatic do_reset();
    cen = 0; zero = 0; cfg_we = 0; cfg_din = 0; eg_in = 0; op_in = 0; noise_mix = 0;
    #2 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    cen = 0; zero = 0; cfg_we = 0; cfg_din = 0; eg_in = 0; op_in = 0; noise_mix = 0;
    rst = 1;
    #2;
    checks++;
    if ({half, op31_no, nfrq, ne, eg_noise, op_out, cfg_pend, sync_err} !== 33'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {half, op31_no, nfrq, ne, eg_noise, op_out, cfg_pend, sync_err});
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_slot_decode();
    int n_half = 0;
    int n_o31 = 0;
    int n_cen = 0;
    while (n_cen < 64) begin
      if ($urandom_range(0, 3) == 0) begin
        step(0, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
      end else begin
        step(1, m_cnt == 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
        n_cen++;
        if (half) n_half++;
        if (op31_no) n_o31++;
      end
      checks++;
      if (half !== ((m_cnt % 16) == 15) || op31_no !== (m_cnt == NS)) begin
        errors++;
        $display("FAIL slot_decode cnt=%0d got half=%b op31=%b", m_cnt, half, op31_no);
      end
      checks++;
      if ({ne, nfrq, cfg_pend, sync_err, eg_noise} !== 18'd0) begin
        errors++;
        $display("FAIL decode_idle got %h required 0", {ne, nfrq, cfg_pend, sync_err, eg_noise});
      end
    end
    checks++;
    if (n_half != 4 || n_o31 != 2) begin
      errors++;
      $display("FAIL strobe_count got half=%0d op31=%0d required 4 and 2", n_half, n_o31);
    end
  endtask

  task automatic test_cfg_apply();
    adv_to(4);
    step(1, 0, 1, 8'h85, 10'h000, 14'h0123, 12'h000);
    while (m_cnt != NS) begin
      checks++;
      if (cfg_pend !== 1'b1 || nfrq !== 5'd0 || ne !== 1'b0) begin
        errors++;
        $display("FAIL cfg_pending cnt=%0d got pend=%b ne=%b nfrq=%0d required 1 0 0",
                 m_cnt, cfg_pend, ne, nfrq);
      end
      step(1, m_cnt == 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    end
    step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (ne !== 1'b1 || nfrq !== 5'd5 || cfg_pend !== 1'b0) begin
      errors++;
      $display("FAIL cfg_apply got ne=%b nfrq=%0d pend=%b required 1 5 0", ne, nfrq, cfg_pend);
    end
  endtask

  task automatic test_last_wins();
    adv_to(3);
    step(1, 0, 1, 8'h81, 10'h000, 14'h0123, 12'h000);
    adv_to(9);
    step(1, 0, 1, 8'h1F, 10'h000, 14'h0123, 12'h000);
    adv_to(NS);
    step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (ne !== 1'b0 || nfrq !== 5'd31 || cfg_pend !== 1'b0) begin
      errors++;
      $display("FAIL last_wins got ne=%b nfrq=%0d pend=%b required 0 31 0", ne, nfrq, cfg_pend);
    end
  endtask

  task automatic test_noise_mux();
    logic [13:0] exp_op;
    adv_to(5);
    step(1, 0, 1, 8'h85, 10'h000, 14'h0123, 12'h800);
    adv_to(NS);
    step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h800);
    for (int i = 0; i < 32; i++) begin
      step(1, m_cnt == 0, 0, 8'h00, 10'h000, 14'h0123, 12'h800);
      exp_op = (prev_cnt == 0) ? 14'h3800 : 14'h0123;
      checks++;
      if (op_out !== exp_op) begin
        errors++;
        $display("FAIL mux_ne1 slot=%0d got %h required %h", prev_cnt, op_out, exp_op);
      end
    end
    adv_to(10);
    step(1, 0, 1, 8'h00, 10'h000, 14'h0123, 12'h800);
    adv_to(NS);
    step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h800);
    for (int i = 0; i < 32; i++) begin
      step(1, m_cnt == 0, 0, 8'h00, 10'h000, 14'h0123, 12'h800);
      checks++;
      if (op_out !== 14'h0123) begin
        errors++;
        $display("FAIL mux_ne0 slot=%0d got %h required 0123", prev_cnt, op_out);
      end
    end
  endtask

  task automatic test_eg_capture();
    adv_to(NS);
    step(1, 0, 0, 8'h00, 10'h2AB, 14'h0123, 12'h000);
    for (int i = 0; i < 31; i++) begin
      step(1, m_cnt == 0, 0, 8'h00, 10'($urandom), 14'h0123, 12'h000);
      checks++;
      if (eg_noise !== 10'h2AB) begin
        errors++;
        $display("FAIL eg_hold slot=%0d got %h required 2ab", prev_cnt, eg_noise);
      end
    end
  endtask

  task automatic test_sync_err();
    adv_to(7);
    step(1, 1, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_err_set got %b required 1", sync_err);
    end
    for (int i = 0; i < 14; i++) step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (half !== 1'b1 || op31_no !== 1'b0 || sync_err !== 1'b1) begin
      errors++;
      $display("FAIL resync_cnt got half=%b op31=%b err=%b required 1 0 1", half, op31_no, sync_err);
    end
  endtask

  task automatic test_reset_mid();
    adv_to(12);
    step(1, 0, 1, 8'h9F, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (cfg_pend !== 1'b1) begin
      errors++;
      $display("FAIL mid_pend got %b required 1", cfg_pend);
    end
    rst = 1;
    #2;
    checks++;
    if ({half, op31_no, nfrq, ne, eg_noise, op_out, cfg_pend, sync_err} !== 33'd0) begin
      errors++;
      $display("FAIL mid_reset got %h required 0",
               {half, op31_no, nfrq, ne, eg_noise, op_out, cfg_pend, sync_err});
    end
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    adv_to(NS);
    step(1, 0, 0, 8'h00, 10'h000, 14'h0123, 12'h000);
    checks++;
    if (ne !== 1'b0 || nfrq !== 5'd0 || cfg_pend !== 1'b0) begin
      errors++;
      $display("FAIL pend_lost got ne=%b nfrq=%0d pend=%b required 0 0 0", ne, nfrq, cfg_pend);
    end
  endtask

  task automatic test_random();
    bit c, z, we;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      c  = ($urandom_range(0, 4) != 0);
      z  = ($urandom_range(0, 60) == 0) ? 1'b1 : (m_cnt == 0);
      we = ($urandom_range(0, 9) == 0);
      step(c, z, we, 8'($urandom), 10'($urandom), 14'($urandom), 12'($urandom));
      checks++;
      if (half !== ((m_cnt % 16) == 15) || op31_no !== (m_cnt == NS) ||
          ne !== m_ne || nfrq !== 5'(m_nfrq) || cfg_pend !== m_pend ||
          eg_noise !== 10'(m_eg) || op_out !== 14'(m_op) || sync_err !== m_err) begin
        errors++;
        $display("FAIL random_%0d got h=%b o=%b ne=%b nf=%0d p=%b eg=%h op=%h se=%b required h=%b o=%b ne=%b nf=%0d p=%b eg=%h op=%h se=%b",
                 i, half, op31_no, ne, nfrq, cfg_pend, eg_noise, op_out, sync_err,
                 ((m_cnt % 16) == 15), (m_cnt == NS), m_ne, m_nfrq, m_pend, 10'(m_eg),
                 14'(m_op), m_err);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_slot_decode();
    test_cfg_apply();
    test_last_wins();
    test_noise_mux();
    test_eg_capture();
    test_sync_err();
    do_reset();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
